uart_debug_bridge: RTL and testbench



---
 rtl/uart_debug_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_debug_bridge.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_debug_bridge.sv
// ---------------------------------------------------------------------------
// uart_debug_bridge
//
// Byte-level command parser that sits between a UART receiver/transmitter
// pair and the system debug memory port. A host reads or writes 32-bit words
// on the system bus with short binary commands:
//
//   Read : 'R' a0 a1 a2 a3           -> response d0 d1 d2 d3 (load, LSB first)
//   Write: 'W' a0 a1 a2 a3 s0 s1 s2 s3 -> response 'K'
//   Other command byte                -> response '?'
//
// Address and store bytes are little-endian (first byte is bits [7:0]).
//
// Handshakes:
//   rx side : rx_valid is a one-cycle strobe with no backpressure. A byte seen
//             in IDLE/ADDR/DATA is consumed in that cycle; a byte seen in
//             MEM/RESP is dropped and sets the sticky err_overrun flag.
//   tx side : valid/ready. tx_valid stays high and tx_data stays stable until
//             the cycle tx_ready is also high; exactly one byte moves on every
//             cycle with tx_valid & tx_ready.
//   dbg side: dbg_read/dbg_write are held, with dbg_addr/dbg_store stable,
//             until dbg_done is sampled high; dbg_load is valid in that cycle.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   rx_valid, rx_data    received byte strobe and data
//   tx_valid, tx_data,   response byte stream to the UART transmitter
//   tx_ready
//   dbg_read, dbg_write  memory request to the debug port
//   dbg_addr, dbg_store  request address and write data
//   dbg_load, dbg_done   read data and completion strobe from the debug port
//   busy                 a command is in progress (state != IDLE)
//   err_overrun          sticky: a byte arrived while it could not be taken
//   fsm_state            current parser state, for observation
// ---------------------------------------------------------------------------
module uart_debug_bridge #(
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  CMD_READ       = 8'h52,
  parameter logic [7:0]  CMD_WRITE      = 8'h57
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        dbg_read,
  output logic        dbg_write,
  output logic [31:0] dbg_addr,
  output logic [31:0] dbg_store,
  input  logic [31:0] dbg_load,
  input  logic        dbg_done,
  output logic        busy,
  output logic        err_overrun,
  output logic [2:0]  fsm_state
);

  // Parser states
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  // Response kinds
  localparam logic [1:0] RK_READ  = 2'd0;
  localparam logic [1:0] RK_WRITE = 2'd1;
  localparam logic [1:0] RK_ERR   = 2'd2;

  localparam logic [7:0] BYTE_OK  = 8'h4B;
  localparam logic [7:0] BYTE_ERR = 8'h3F;

  // Timer must be able to hold TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    r_state;
  logic          r_op_write;
  logic [1:0]    r_resp_kind;
  logic [1:0]    r_byte_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_store;
  logic [31:0]   r_load;
  logic [TW-1:0] r_timer;
  logic          r_overrun;

  logic [7:0]    w_tx_byte;
  logic          w_tx_last;
  logic          w_rx_blocked;

  // A byte cannot be taken while a request or response is in flight.
  assign w_rx_blocked = (r_state == S_MEM) || (r_state == S_RESP);

  // Response byte selection; read data goes out LSB first.
  always_comb begin
    w_tx_byte = 8'h00;
    w_tx_last = 1'b1;
    case (r_resp_kind)
      RK_READ: begin
        w_tx_byte = r_load[{r_byte_cnt, 3'b000} +: 8];
        w_tx_last = (r_byte_cnt == 2'd3);
      end
      RK_WRITE: w_tx_byte = BYTE_OK;
      default:  w_tx_byte = BYTE_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op_write  <= 1'b0;
      r_resp_kind <= RK_READ;
      r_byte_cnt  <= 2'd0;
      r_addr      <= 32'h0;
      r_store     <= 32'h0;
      r_load      <= 32'h0;
      r_timer     <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (rx_valid && w_rx_blocked) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_timer    <= '0;
          r_byte_cnt <= 2'd0;
          if (rx_valid) begin
            if (rx_data == CMD_READ) begin
              r_op_write <= 1'b0;
              r_state    <= S_ADDR;
            end else if (rx_data == CMD_WRITE) begin
              r_op_write <= 1'b1;
              r_state    <= S_ADDR;
            end else begin
              r_resp_kind <= RK_ERR;
              r_state     <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          // A byte on the expiry cycle wins over the timeout.
          if (rx_valid) begin
            r_timer                          <= '0;
            r_addr[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
            r_byte_cnt                       <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state <= r_op_write ? S_DATA : S_MEM;
            end
          end else if (r_timer == TIMER_LAST) begin
            r_timer    <= '0;
            r_byte_cnt <= 2'd0;
            r_state    <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            r_timer                           <= '0;
            r_store[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
            r_byte_cnt                        <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state <= S_MEM;
            end
          end else if (r_timer == TIMER_LAST) begin
            r_timer    <= '0;
            r_byte_cnt <= 2'd0;
            r_state    <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_MEM: begin
          // No timeout here: the bus is trusted to complete eventually.
          r_timer <= '0;
          if (dbg_done) begin
            if (!r_op_write) begin
              r_load <= dbg_load;
            end
            r_resp_kind <= r_op_write ? RK_WRITE : RK_READ;
            r_byte_cnt  <= 2'd0;
            r_state     <= S_RESP;
          end
        end

        S_RESP: begin
          r_timer <= '0;
          if (tx_ready) begin
            if (w_tx_last) begin
              r_byte_cnt <= 2'd0;
              r_state    <= S_IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_byte_cnt <= 2'd0;
          r_timer    <= '0;
        end
      endcase
    end
  end

  assign tx_valid    = (r_state == S_RESP);
  assign tx_data     = (r_state == S_RESP) ? w_tx_byte : 8'h00;
  assign dbg_read    = (r_state == S_MEM) && !r_op_write;
  assign dbg_write   = (r_state == S_MEM) &&  r_op_write;
  assign dbg_addr    = r_addr;
  assign dbg_store   = r_store;
  assign busy        = (r_state != S_IDLE);
  assign err_overrun = r_overrun;
  assign fsm_state   = r_state;

endmodule

// File: tb/tb_uart_debug_bridge.sv
// ---------------------------------------------------------------------------
// tb_uart_debug_bridge
//
// Directed bench for uart_debug_bridge. Expected response bytes are queued
// when a command is issued; a monitor pops and compares them on every tx
// handshake. A small memory model answers debug requests with a set latency
// and checks the request fields while they are held.
// ---------------------------------------------------------------------------
module tb_uart_debug_bridge;

  localparam int TO_CYCLES = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        dbg_read;
  logic        dbg_write;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_store;
  logic [31:0] dbg_load;
  logic        dbg_done;
  logic        busy;
  logic        err_overrun;
  logic [2:0]  fsm_state;

  uart_debug_bridge #(
    .TIMEOUT_CYCLES (TO_CYCLES),
    .CMD_READ       (8'h52),
    .CMD_WRITE      (8'h57)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .dbg_read    (dbg_read),
    .dbg_write   (dbg_write),
    .dbg_addr    (dbg_addr),
    .dbg_store   (dbg_store),
    .dbg_load    (dbg_load),
    .dbg_done    (dbg_done),
    .busy        (busy),
    .err_overrun (err_overrun),
    .fsm_state   (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model controls ----------------
  logic        exp_op_write = 1'b0;
  logic [31:0] exp_addr     = 32'h0;
  logic [31:0] exp_store    = 32'h0;
  logic [31:0] mem_rdata    = 32'h0;
  int          mem_latency  = 1;
  logic        mem_hold     = 1'b0;
  int          last_req_cycles = 0;
  int          req_total    = 0;

  // ---------------- tx_ready driver ----------------
  int ready_mode = 0;  // 0: always ready, 1: pattern 1,0,0,1 repeating
  int rdy_idx    = 0;

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        tx_ready = 1'b1;
      end else begin
        tx_ready = ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3);
        rdy_idx++;
      end
    end
  end

  // ---------------- memory model ----------------
  initial begin
    int cyc;
    cyc      = 0;
    dbg_done = 1'b0;
    dbg_load = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dbg_done = 1'b0;
        cyc      = 0;
      end else if (dbg_done) begin
        // Request must have dropped on the edge that sampled done.
        dbg_done = 1'b0;
        check("req_drop", {30'h0, dbg_read, dbg_write}, 32'h0);
        last_req_cycles = cyc;
        cyc = 0;
      end else if (dbg_read || dbg_write) begin
        cyc++;
        req_total++;
        check("req_op", {30'h0, dbg_read, dbg_write}, exp_op_write ? 32'h1 : 32'h2);
        check("req_addr", dbg_addr, exp_addr);
        if (exp_op_write) begin
          check("req_store", dbg_store, exp_store);
        end
        if (!mem_hold && cyc >= mem_latency) begin
          dbg_done = 1'b1;
          dbg_load = mem_rdata;
        end
      end
    end
  end

  // ---------------- tx monitor ----------------
  initial begin
    logic       held_valid;
    logic [7:0] held_data;
    logic [7:0] exp_b;
    held_valid = 1'b0;
    held_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_valid = 1'b0;
      end else begin
        if (held_valid) begin
          check("tx_hold_valid", {31'h0, tx_valid}, 32'h1);
          check("tx_hold_data", {24'h0, tx_data}, {24'h0, held_data});
        end
        held_valid = tx_valid && !tx_ready;
        held_data  = tx_data;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL tx_unexpected: got %h expected no byte at %0t", tx_data, $time);
          end else begin
            exp_b = exp_q.pop_front();
            check("tx_byte", {24'h0, tx_data}, {24'h0, exp_b});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (busy || exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: busy=%0b pending=%0d after %0d cycles", name, busy, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tx_valid"},  {31'h0, tx_valid},  32'h0);
    check({name, "_tx_data"},   {24'h0, tx_data},   32'h0);
    check({name, "_dbg_read"},  {31'h0, dbg_read},  32'h0);
    check({name, "_dbg_write"}, {31'h0, dbg_write}, 32'h0);
    check({name, "_dbg_addr"},  dbg_addr,           32'h0);
    check({name, "_dbg_store"}, dbg_store,          32'h0);
    check({name, "_busy"},      {31'h0, busy},      32'h0);
    check({name, "_overrun"},   {31'h0, err_overrun}, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int snap;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Write: 57 10 00 00 80 EF BE AD DE -> 4B
    exp_op_write = 1'b1;
    exp_addr     = 32'h80000010;
    exp_store    = 32'hDEADBEEF;
    mem_latency  = 3;
    exp_q.push_back(8'h4B);
    send_byte(8'h57);
    send_word(32'h80000010);
    send_word(32'hDEADBEEF);
    wait_idle("write", 200);
    check("write_req_cycles", last_req_cycles, 32'd3);
    check("write_tx_valid_after", {31'h0, tx_valid}, 32'h0);

    // Read with tx_ready toggling 1,0,0,1
    exp_op_write = 1'b0;
    exp_addr     = 32'h80000010;
    mem_rdata    = 32'hCAFEF00D;
    mem_latency  = 5;
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'hCA);
    rdy_idx    = 0;
    ready_mode = 1;
    send_byte(8'h52);
    send_word(32'h80000010);
    wait_idle("read", 200);
    ready_mode = 0;
    check("read_req_cycles", last_req_cycles, 32'd5);

    // Bad command
    snap = req_total;
    exp_q.push_back(8'h3F);
    send_byte(8'h41);
    wait_idle("badcmd", 50);
    check("badcmd_no_req", req_total, snap);
    check("badcmd_busy", {31'h0, busy}, 32'h0);

    // Timeout: partial read abandoned, then a full write
    send_byte(8'h52);
    send_byte(8'h10);
    check("timeout_busy_before", {31'h0, busy}, 32'h1);
    repeat (20) @(posedge clk);
    #1;
    check("timeout_busy_after", {31'h0, busy}, 32'h0);
    exp_op_write = 1'b1;
    exp_addr     = 32'h00001234;
    exp_store    = 32'h01020304;
    mem_latency  = 2;
    exp_q.push_back(8'h4B);
    send_byte(8'h57);
    send_word(32'h00001234);
    send_word(32'h01020304);
    wait_idle("timeout_write", 200);
    check("timeout_write_req_cycles", last_req_cycles, 32'd2);

    // Overrun during a pending read
    exp_op_write = 1'b0;
    exp_addr     = 32'h00000040;
    mem_rdata    = 32'h11223344;
    mem_latency  = 1;
    mem_hold     = 1'b1;
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h11);
    send_byte(8'h52);
    send_word(32'h00000040);
    repeat (2) @(posedge clk);
    #1;
    check("ovr_read_pending", {31'h0, dbg_read}, 32'h1);
    check("ovr_before", {31'h0, err_overrun}, 32'h0);
    send_byte(8'h55);
    check("ovr_set", {31'h0, err_overrun}, 32'h1);
    repeat (3) @(posedge clk);
    mem_hold = 1'b0;
    wait_idle("ovr_read", 200);
    check("ovr_sticky", {31'h0, err_overrun}, 32'h1);

    // Reset in DATA after two data bytes
    exp_op_write = 1'b1;
    exp_addr     = 32'h00000100;
    exp_store    = 32'h0;
    send_byte(8'h57);
    send_word(32'h00000100);
    send_byte(8'hAA);
    send_byte(8'hBB);
    check("rst_data_state", {29'h0, fsm_state}, 32'd2);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("rst_data");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset in MEM with the request outstanding
    exp_op_write = 1'b1;
    exp_addr     = 32'h00000200;
    exp_store    = 32'h55667788;
    mem_hold     = 1'b1;
    send_byte(8'h57);
    send_word(32'h00000200);
    send_word(32'h55667788);
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_write_pending", {31'h0, dbg_write}, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mem");
    mem_hold = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Clean read after reset
    exp_op_write = 1'b0;
    exp_addr     = 32'h00000100;
    mem_rdata    = 32'hA5A55A5A;
    mem_latency  = 1;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    send_byte(8'h52);
    send_word(32'h00000100);
    wait_idle("clean_read", 200);
    check("clean_read_req_cycles", last_req_cycles, 32'd1);
    check("final_busy", {31'h0, busy}, 32'h0);
    check("final_queue_empty", exp_q.size(), 32'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
